mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single-ported unified instruction/data memory of the pipelined core. It shares the memory between the fetch stage (IF) and the load/store stage (DS), holds the memory bus stable until the memory acknowledges, and returns completion pulses that the hazard logic uses as stall-release. Data accesses take priority, and a starvation counter guarantees forward progress for fetch. A watchdog terminates hung memory transactions with an error response.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one unified memory port between fetch (IF) and load/store (DS).
// DS has priority, a starvation counter guarantees fetch progress, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        ds_req,
    input  logic        ds_we,
    input  logic [1:0]  ds_size,
    input  logic [31:0] ds_addr,
    input  logic [31:0] ds_wdata,
    output logic        ds_valid,
    output logic [31:0] ds_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DS} state_t;

    localparam logic [3:0] SMAX    = 4'(STARVE_MAX);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt;
    logic [7:0]  to_cnt;
    logic        busy, timeout, done;
    logic        grant_if, grant_ds;

    assign busy    = (state != IDLE);
    // An ack in the last watchdog cycle wins over the abort.
    assign timeout = busy && (to_cnt == TO_LAST) && !mem_ack;
    assign done    = busy && (mem_ack || timeout);

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_ds  = 1'b0;
        if_valid  = 1'b0;
        ds_valid  = 1'b0;
        if_rdata  = '0;
        ds_rdata  = '0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                grant_ds = ds_req && !(if_req && (starve_cnt == SMAX));
                grant_if = if_req && !grant_ds;
                if (grant_ds)      state_nxt = BUSY_DS;
                else if (grant_if) state_nxt = BUSY_IF;
            end
            BUSY_IF: begin
                if (done) begin
                    if_valid  = 1'b1;
                    err       = timeout;
                    if_rdata  = mem_ack ? mem_rdata : '0;
                    state_nxt = IDLE;
                end
            end
            BUSY_DS: begin
                if (done) begin
                    ds_valid  = 1'b1;
                    err       = timeout;
                    ds_rdata  = (mem_ack && !mem_we) ? mem_rdata : '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Memory bus registers only change on a grant or at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_ds) begin
            mem_req   <= 1'b1;
            mem_we    <= ds_we;
            mem_size  <= ds_size;
            mem_addr  <= ds_addr;
            mem_wdata <= ds_wdata;
        end else if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_size  <= 2'b10;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if || !if_req)
                starve_cnt <= '0;
            else if (grant_ds && (starve_cnt != SMAX))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  to_cnt <= '0;
        else if (grant_if || grant_ds) to_cnt <= '0;
        else if (busy && !mem_ack)   to_cnt <= to_cnt + 8'd1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        ds_req;
    logic        ds_we;
    logic [1:0]  ds_size;
    logic [31:0] ds_addr;
    logic [31:0] ds_wdata;
    logic        ds_valid;
    logic [31:0] ds_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .ds_req(ds_req), .ds_we(ds_we), .ds_size(ds_size), .ds_addr(ds_addr),
        .ds_wdata(ds_wdata), .ds_valid(ds_valid), .ds_rdata(ds_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order[$];
        int exp_order[7];
        int nds;
        bit ds_done;

        exp_order = '{1, 1, 1, 1, 0, 1, 1};
        rst_n = 1'b0; if_req = 0; if_addr = 0; ds_req = 0; ds_we = 0; ds_size = 0;
        ds_addr = 0; ds_wdata = 0; mem_ack = 0; mem_rdata = 0;
        #2;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_size", 32'(mem_size), 0);
        chk("rst_valids", {30'd0, if_valid, ds_valid}, 0);
        chk("rst_err", 32'(err), 0);
        step(); step();
        rst_n = 1'b1;

        // Fetch only
        step();
        if_req = 1; if_addr = 32'h100;
        #1 chk("f_idle_mem_req", 32'(mem_req), 0);
        step();
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        #1;
        chk("f_mem_req", 32'(mem_req), 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_size", 32'(mem_size), 2);
        chk("f_if_valid", 32'(if_valid), 1);
        chk("f_if_rdata", if_rdata, 32'h0050_0093);
        chk("f_err", 32'(err), 0);
        chk("f_ds_valid", 32'(ds_valid), 0);
        step();
        if_req = 0; mem_ack = 0;
        #1;
        chk("f_done_mem_req", 32'(mem_req), 0);
        chk("f_done_if_valid", 32'(if_valid), 0);

        // Contention: DS store wins, IF follows
        step();
        if_req = 1; if_addr = 32'h104;
        ds_req = 1; ds_we = 1; ds_size = 2'b10; ds_addr = 32'h2004; ds_wdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        #1;
        chk("c_mem_we", 32'(mem_we), 1);
        chk("c_mem_addr", mem_addr, 32'h2004);
        chk("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("c_ds_valid", 32'(ds_valid), 1);
        chk("c_ds_rdata", ds_rdata, 0);
        chk("c_if_valid", 32'(if_valid), 0);
        step();
        ds_req = 0; ds_we = 0; mem_ack = 0;
        #1 chk("c_gap_mem_req", 32'(mem_req), 0);
        step();
        chk("c_if_mem_req", 32'(mem_req), 1);
        chk("c_if_mem_addr", mem_addr, 32'h104);
        chk("c_if_mem_we", 32'(mem_we), 0);
        chk("c_if_mem_wdata", mem_wdata, 0);
        mem_ack = 1; mem_rdata = 32'h0000_A5A5;
        #1;
        chk("c_if_valid2", 32'(if_valid), 1);
        chk("c_if_rdata", if_rdata, 32'h0000_A5A5);
        step();
        if_req = 0; mem_ack = 0;

        // Starvation: IF held, DS issues 6 back-to-back loads
        step();
        if_req = 1; if_addr = 32'h200;
        ds_req = 1; ds_we = 0; ds_size = 2'b10; ds_addr = 32'h3000;
        nds = 0; ds_done = 0;
        for (int cyc = 0; cyc < 60 && order.size() < 7; cyc++) begin
            step();
            if (ds_done) begin
                ds_done = 0;
                nds++;
                if (nds == 6) ds_req = 0;
                else          ds_addr = 32'h3000 + 32'(4 * nds);
            end
            mem_ack   = mem_req;
            mem_rdata = mem_addr ^ 32'h5555_0000;
            #1;
            if (ds_valid) begin
                order.push_back(1);
                ds_done = 1;
                chk("s_ds_rdata", ds_rdata, (32'h3000 + 32'(4 * nds)) ^ 32'h5555_0000);
            end
            if (if_valid) order.push_back(0);
        end
        chk("s_grant_count", 32'(order.size()), 7);
        for (int i = 0; i < 7; i++)
            if (i < order.size()) chk($sformatf("s_grant_%0d", i), 32'(order[i]), 32'(exp_order[i]));
        step();
        if_req = 0; ds_req = 0; mem_ack = 0;
        step();

        // Timeout: no ack for 8 cycles
        ds_req = 1; ds_we = 0; ds_addr = 32'h4000; mem_rdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("t_mem_req_%0d", k), 32'(mem_req), 1);
            if (k < 8) begin
                chk($sformatf("t_ds_valid_%0d", k), 32'(ds_valid), 0);
            end else begin
                chk("t_ds_valid", 32'(ds_valid), 1);
                chk("t_err", 32'(err), 1);
                chk("t_ds_rdata", ds_rdata, 0);
            end
        end
        step();
        ds_req = 0;
        #1;
        chk("t_after_mem_req", 32'(mem_req), 0);
        chk("t_after_err", 32'(err), 0);
        chk("t_after_ds_valid", 32'(ds_valid), 0);

        // Ack exactly in the last watchdog cycle
        step();
        ds_req = 1; ds_addr = 32'h4004;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k < 8) begin
                chk($sformatf("b_ds_valid_%0d", k), 32'(ds_valid), 0);
            end else begin
                mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
                #1;
                chk("b_ds_valid", 32'(ds_valid), 1);
                chk("b_err", 32'(err), 0);
                chk("b_ds_rdata", ds_rdata, 32'hCAFE_F00D);
            end
        end
        step();
        ds_req = 0; mem_ack = 0;

        // Async reset in BUSY_DS
        step();
        ds_req = 1; ds_addr = 32'h5000;
        step();
        chk("r_busy_mem_req", 32'(mem_req), 1);
        #2;
        rst_n = 0;
        #1;
        chk("r_mem_req", 32'(mem_req), 0);
        chk("r_mem_addr", mem_addr, 0);
        mem_ack = 1;
        #1 chk("r_ds_valid", 32'(ds_valid), 0);
        step();
        ds_req = 0; mem_ack = 0; rst_n = 1;
        step();
        if_req = 1; if_addr = 32'h300;
        step();
        mem_ack = 1; mem_rdata = 32'h0000_0013;
        #1;
        chk("r_f_mem_addr", mem_addr, 32'h300);
        chk("r_f_if_valid", 32'(if_valid), 1);
        chk("r_f_if_rdata", if_rdata, 32'h0000_0013);
        chk("r_f_err", 32'(err), 0);
        step();
        if_req = 0; mem_ack = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
